// File: rtl/write_back_stage.sv
// Final pipeline stage: write-back source mux, 8x16 register file with
// write-through read bypass, and two-beat return-PC reassembly for fetch.
module write_back_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic [DATA_WIDTH-1:0]   data_r,
  input  logic [DATA_WIDTH-1:0]   LDM_value,
  input  logic [DATA_WIDTH-1:0]   in_port,
  input  logic [1:0]              wb_sel,
  input  logic                    reg_write,
  input  logic [ADDR_WIDTH-1:0]   rdst,
  input  logic [ADDR_WIDTH-1:0]   rsrc1,
  input  logic [ADDR_WIDTH-1:0]   rsrc2,
  output logic [DATA_WIDTH-1:0]   read_data1,
  output logic [DATA_WIDTH-1:0]   read_data2,
  output logic [DATA_WIDTH-1:0]   wb_data,
  input  logic                    pc_pop_valid,
  input  logic                    pc_enable,
  output logic                    pc_enable_out,
  output logic [2*DATA_WIDTH-1:0] pc_out,
  output logic                    pc_load
);

  typedef enum logic {IDLE, HIGH_HELD} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] hi_latch;

  always_comb begin
    wb_data = alu_result;
    unique case (wb_sel)
      2'b00: wb_data = alu_result;
      2'b01: wb_data = data_r;
      2'b10: wb_data = LDM_value;
      2'b11: wb_data = in_port;
      default: wb_data = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (reg_write) begin
      regs[rdst] <= wb_data;
    end
  end

  // Write-through: decode sees the value being committed this cycle.
  always_comb begin
    read_data1 = (reg_write && (rsrc1 == rdst)) ? wb_data : regs[rsrc1];
    read_data2 = (reg_write && (rsrc2 == rdst)) ? wb_data : regs[rsrc2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (pc_pop_valid) state_next = HIGH_HELD;
      HIGH_HELD: if (pc_pop_valid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_enable_out = pc_enable && (state == IDLE) && !pc_pop_valid;
  end

  // First popped beat is always PC[31:16]; the second completes the PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_latch <= '0;
      pc_out   <= '0;
      pc_load  <= 1'b0;
    end else begin
      pc_load <= 1'b0;
      if (pc_pop_valid) begin
        if (state == IDLE) begin
          hi_latch <= data_r;
        end else begin
          pc_out  <= {hi_latch, data_r};
          pc_load <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
Final pipeline stage; consumes the memory-stage buffer outputs (data_r, LDM_value_out, wb_sel_out, reg_write_out, pc_enable_out) plus the forwarded ALU result and input port.
Selects the write-back value and commits it to an 8x16 register file, which it owns. The register file serves the decode stage through two read ports with write-through bypass.
Also reassembles 32-bit return PCs popped from the stack as two 16-bit beats, and presents them to fetch as a one-cycle load.

Parameters:
DATA_WIDTH, 16, register and write-back data width
REG_COUNT, 8, number of general-purpose registers
ADDR_WIDTH, 3, register address width (log2 REG_COUNT)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous active-low reset
alu_result  in  16  forwarded execute result
data_r  in  16  memory read data from memory-stage buffer
LDM_value  in  16  immediate load value from memory-stage buffer
in_port  in  16  external input port value
wb_sel  in  2  write-back source select
reg_write  in  1  commit enable
rdst  in  3  destination register
rsrc1  in  3  read port 1 address (decode)
rsrc2  in  3  read port 2 address (decode)
read_data1  out  16  register file read port 1
read_data2  out  16  register file read port 2
wb_data  out  16  selected write-back value (for forwarding)
pc_pop_valid  in  1  data_r carries one popped PC half this cycle
pc_enable  in  1  fetch-advance permission from memory-stage buffer
pc_enable_out  out  1  fetch-advance permission to fetch stage
pc_out  out  32  reassembled return PC
pc_load  out  1  one-cycle pulse: fetch must load pc_out

Behaviour:
- Clocking: single clock domain. Reset is asynchronous and active-low; all state clears immediately on reset=0, independent of clk.
- Reset values:
  - All REG_COUNT registers = 0.
  - FSM = IDLE; hi_latch = 0.
  - pc_out = 0; pc_load = 0.
  - read_data1/2 and wb_data are combinational and reflect the cleared state.
- Write-back mux (combinational): wb_sel 00 -> alu_result, 01 -> data_r, 10 -> LDM_value, 11 -> in_port. The result drives wb_data.
- Register file write:
  - On a rising edge with reg_write=1, regs[rdst] <= wb_data.
  - Latency 1 cycle.
  - No register is hard-wired to zero.
- Register file read:
  - Combinational on rsrc1/rsrc2.
  - Bypass: if reg_write=1 and rsrcN==rdst, read_dataN = wb_data in the same cycle; otherwise regs[rsrcN].
  - Both ports may hit the same register and may both bypass.
- PC reassembly FSM (states IDLE, HIGH_HELD):
  - IDLE + pc_pop_valid: hi_latch <= data_r; go to HIGH_HELD. The first beat is always PC[31:16].
  - HIGH_HELD + pc_pop_valid: pc_out <= {hi_latch, data_r}; pc_load <= 1 for exactly one cycle; return to IDLE.
  - HIGH_HELD without pc_pop_valid: hold state and hi_latch indefinitely (bubbles between beats are legal).
  - pc_load is registered; it is 0 in every cycle other than the one following the second beat.
  - pc_out holds its last value until the next completed reassembly.
- pc_enable_out (combinational) = pc_enable AND (state==IDLE) AND NOT pc_pop_valid.
  - Fetch is frozen from the first beat until the cycle the second beat is accepted.
  - It is released in the cycle pc_load is high.
- Simultaneous events:
  - reg_write and pc_pop_valid in the same cycle are independent; both the register write and the FSM advance occur.
  - A back-to-back next pop beat in the cycle pc_load=1 starts a new reassembly from IDLE.
- Reset mid-operation: reset asserted in HIGH_HELD discards hi_latch, forces IDLE and pc_load=0; no partial PC is ever emitted.
- Out-of-range indices: rdst/rsrc are full-range for REG_COUNT=8; no out-of-range case exists at default parameters.

Test Plan:
1. Reset, then read all 8 registers -> read_data1/2 = 0x0000; pc_load=0; pc_out=0; pc_enable_out follows pc_enable.
2. wb_sel=10, LDM_value=0xBEEF, rdst=3, reg_write=1 for 1 cycle; next cycle rsrc1=3 -> read_data1=0xBEEF. wb_sel=01, data_r=0x1234 -> wb_data=0x1234.
3. Same-cycle bypass: reg_write=1, rdst=5, wb_sel=00, alu_result=0x00A5, rsrc1=rsrc2=5 -> both read ports = 0x00A5 before the clock edge; regs[5]=0x00A5 after it.
4. Pop sequence: pc_pop_valid with data_r=0x0001, two idle cycles, then pc_pop_valid with data_r=0x2040 -> pc_out=0x00012040 and pc_load=1 for exactly one cycle; pc_enable_out=0 from the first beat through the second beat.
5. Reset mid-reassembly: first beat 0xFFFF, reset low for 1 cycle, then single beat 0x0010 -> no pc_load; FSM in HIGH_HELD with hi_latch=0x0010.
6. Simultaneous: pc_pop_valid second beat together with reg_write=1, rdst=7, wb_sel=11, in_port=0x5A5A -> pc_load pulse asserted and regs[7]=0x5A5A.
